param_interval_timer: RTL and testbench
=======================================

PARAM_INTERVAL_TIMER -- requirements
Module: param_interval_timer

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32, counter/period width, legal 8..64.
REQ-002 SHALL have parameter RESET_PERIOD, default 499, period and counter value after reset.
REQ-003 SHALL have parameter PRESCALE_WIDTH, default 8, prescaler register width, legal 1..16.
REQ-004 SHALL have parameter AUTO_START, default 0; 1 = RUN and CONT set by reset.
REQ-005 SHALL have port clk, input, 1, sole clock; one clock domain.
REQ-006 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have ports address input 3, chipselect input 1, write_n input 1 (active low), writedata input 32.
REQ-008 SHALL have ports readdata output 32, irq output 1 (level), timeout_pulse output 1 (one-cycle strobe).

Function
REQ-009 SHALL decode a write strobe as chipselect && !write_n; reads SHALL register read mux into readdata every cycle, 1-cycle latency, no chipselect qualification.
REQ-010 SHALL implement map: 0 STATUS {bit1 RUN, bit0 TO}; 1 CONTROL {bit3 STOP, bit2 START, bit1 CONT, bit0 ITO}; 2 PERIOD_LO; 3 PERIOD_HI; 4 SNAP_LO; 5 SNAP_HI; 6 PRESCALE; 7 TOCOUNT[15:0].
REQ-011 SHALL store CONTROL bits 3:0 on write; START/STOP SHALL act only in the write cycle; reads SHALL return the stored bits.
REQ-012 SHALL zero-extend all reads; period/snapshot bits at or above COUNTER_WIDTH SHALL read 0 and ignore writes (PERIOD_HI/SNAP_HI read 0 when COUNTER_WIDTH <= 32).
REQ-013 SHALL generate tick: prescale counter loads PRESCALE and decrements each cycle while RUN; tick when it is 0, then reloads; PRESCALE=P gives one tick per P+1 cycles; prescale counter SHALL reload on START.
REQ-014 SHALL decrement counter by 1 on each tick while RUN and counter != 0.
REQ-015 SHALL on a tick with RUN and counter == 0 raise a timeout event: counter <= period, TO <= 1, timeout_pulse high that cycle + 1 (registered), TOCOUNT increments.
REQ-016 SHALL clear RUN on a timeout event when CONT == 0; counter still reloads.
REQ-017 SHALL on any PERIOD_LO/PERIOD_HI write set force_reload next cycle: counter <= new period, RUN <= 0, prescale counter reloads.
REQ-018 SHALL give START priority over STOP and over force_reload in the same cycle (RUN <= 1).
REQ-019 SHALL clear TO and TOCOUNT on any STATUS write; a same-cycle timeout event SHALL win (TO=1, TOCOUNT=1).
REQ-020 SHALL saturate TOCOUNT at 16'hFFFF.
REQ-021 SHALL capture the full counter into the snapshot register atomically on a write to SNAP_LO or SNAP_HI; data written is ignored.
REQ-022 SHALL drive irq = TO && ITO, combinationally from registers.
REQ-023 SHALL with period 0 and CONT=1 raise a timeout on every tick.
REQ-024 SHALL keep counter and prescale state frozen while RUN == 0.

Reset
REQ-025 SHALL on reset set counter and period to RESET_PERIOD, PRESCALE 0, snapshot 0, TOCOUNT 0, TO 0, CONTROL 0 (CONT=1 if AUTO_START), RUN = AUTO_START, readdata 0, irq 0, timeout_pulse 0.
REQ-026 SHALL let reset mid-count override all bus activity in that cycle.

Verification
REQ-027 Reset, PRESCALE 0, write CONTROL=4'b0111 -> timeout_pulse 501 cycles after write (500 ticks plus register), irq high, STATUS reads 2'b11.
REQ-028 PERIOD_LO=3, CONT=0, START -> one timeout after 4 ticks, RUN reads 0, counter holds 3, TOCOUNT=1.
REQ-029 PRESCALE=2, PERIOD_LO=1, CONT=1, START -> timeout_pulse every 6 cycles; STATUS write coincident with timeout -> TO stays 1, TOCOUNT=1.
REQ-030 COUNTER_WIDTH=40, PERIOD_HI=0x12, PERIOD_LO=0x34, START, run 10 ticks, write SNAP_LO -> SNAP_HI 0x12, SNAP_LO 0x2A.
REQ-031 CONTROL write 4'b1100 while stopped -> RUN=1; PERIOD write then START on force_reload cycle -> RUN=1, counter = new period.
REQ-032 Period 0, CONT=1, run 70000 ticks -> TOCOUNT reads 0xFFFF; reset asserted mid-run -> all REQ-025 values next cycle.

Source files
------------

// File: rtl/param_interval_timer_if.sv
// Register-bus bundle for param_interval_timer: 3-bit word address, write strobe
// qualified by chipselect, and a registered read-data return path.
interface param_interval_timer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/param_interval_timer.sv
// Prescaled down-counting interval timer with reload period, snapshot capture,
// saturating timeout counter and level/pulse timeout outputs.
module param_interval_timer #(
    parameter int              COUNTER_WIDTH  = 32,
    parameter longint unsigned RESET_PERIOD   = 64'd499,
    parameter int              PRESCALE_WIDTH = 8,
    parameter bit              AUTO_START     = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    param_interval_timer_if.slave bus,
    output logic                  irq,
    output logic                  timeout_pulse
);

    localparam int CW = COUNTER_WIDTH;
    localparam int PW = PRESCALE_WIDTH;

    localparam logic [CW-1:0] RST_PERIOD = CW'(RESET_PERIOD);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [PW-1:0] PRE_ZERO   = PW'(1'b0);
    localparam logic [PW-1:0] PRE_ONE    = PW'(1'b1);
    localparam logic [3:0]    RST_CTRL   = AUTO_START ? 4'b0010 : 4'b0000;

    localparam logic [2:0] A_STATUS    = 3'd0;
    localparam logic [2:0] A_CONTROL   = 3'd1;
    localparam logic [2:0] A_PERIOD_LO = 3'd2;
    localparam logic [2:0] A_PERIOD_HI = 3'd3;
    localparam logic [2:0] A_SNAP_LO   = 3'd4;
    localparam logic [2:0] A_SNAP_HI   = 3'd5;
    localparam logic [2:0] A_PRESCALE  = 3'd6;
    localparam logic [2:0] A_TOCOUNT   = 3'd7;

    logic [3:0]    ctrl_q, ctrl_d;
    logic          run_q, run_d;
    logic          to_q, to_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] counter_q, counter_d;
    logic [CW-1:0] snap_q, snap_d;
    logic [PW-1:0] prescale_q, prescale_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [15:0]   tocount_q, tocount_d;
    logic          force_reload_q, force_reload_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          timeout_pulse_q, timeout_pulse_d;

    logic          wr_s;
    logic          wr_status_s, wr_ctrl_s, wr_plo_s, wr_phi_s, wr_snap_s, wr_pre_s;
    logic          start_s, stop_s, tick_s, timeout_s;
    logic [63:0]   period_ext_s, snap_ext_s;

    // Bus write decode and tick/timeout event detection
    always_comb begin
        wr_s         = bus.chipselect && !bus.write_n;
        wr_status_s  = wr_s && (bus.address == A_STATUS);
        wr_ctrl_s    = wr_s && (bus.address == A_CONTROL);
        wr_plo_s     = wr_s && (bus.address == A_PERIOD_LO);
        wr_phi_s     = wr_s && (bus.address == A_PERIOD_HI);
        wr_snap_s    = wr_s && ((bus.address == A_SNAP_LO) || (bus.address == A_SNAP_HI));
        wr_pre_s     = wr_s && (bus.address == A_PRESCALE);
        start_s      = wr_ctrl_s && bus.writedata[2];
        stop_s       = wr_ctrl_s && bus.writedata[3];
        tick_s       = run_q && (pre_cnt_q == PRE_ZERO);
        timeout_s    = tick_s && (counter_q == CNT_ZERO);
        period_ext_s = 64'(period_q);
        snap_ext_s   = 64'(snap_q);
    end

    // Next-state for counter, prescaler, run flag and the register file
    always_comb begin
        // START beats STOP and force_reload; a one-shot timeout clears RUN
        if (start_s) begin
            run_d = 1'b1;
        end else if (stop_s || force_reload_q) begin
            run_d = 1'b0;
        end else if (timeout_s && !ctrl_q[1]) begin
            run_d = 1'b0;
        end else begin
            run_d = run_q;
        end

        if (start_s || force_reload_q || tick_s) begin
            pre_cnt_d = prescale_q;
        end else if (run_q) begin
            pre_cnt_d = pre_cnt_q - PRE_ONE;
        end else begin
            pre_cnt_d = pre_cnt_q;
        end

        if (force_reload_q || timeout_s) begin
            counter_d = period_q;
        end else if (tick_s) begin
            counter_d = counter_q - CNT_ONE;
        end else begin
            counter_d = counter_q;
        end

        if (timeout_s) begin
            to_d      = 1'b1;
            tocount_d = wr_status_s ? 16'd1 :
                        ((tocount_q == 16'hFFFF) ? 16'hFFFF : tocount_q + 16'd1);
        end else if (wr_status_s) begin
            to_d      = 1'b0;
            tocount_d = 16'd0;
        end else begin
            to_d      = to_q;
            tocount_d = tocount_q;
        end

        ctrl_d          = wr_ctrl_s ? bus.writedata[3:0] : ctrl_q;
        period_d        = CW'({wr_phi_s ? bus.writedata : period_ext_s[63:32],
                               wr_plo_s ? bus.writedata : period_ext_s[31:0]});
        force_reload_d  = wr_plo_s || wr_phi_s;
        snap_d          = wr_snap_s ? counter_q : snap_q;
        prescale_d      = wr_pre_s ? PW'(bus.writedata) : prescale_q;
        timeout_pulse_d = timeout_s;
    end

    // Read mux, registered unconditionally every cycle
    always_comb begin
        case (bus.address)
            A_STATUS:    readdata_d = {30'd0, run_q, to_q};
            A_CONTROL:   readdata_d = {28'd0, ctrl_q};
            A_PERIOD_LO: readdata_d = period_ext_s[31:0];
            A_PERIOD_HI: readdata_d = period_ext_s[63:32];
            A_SNAP_LO:   readdata_d = snap_ext_s[31:0];
            A_SNAP_HI:   readdata_d = snap_ext_s[63:32];
            A_PRESCALE:  readdata_d = 32'(prescale_q);
            A_TOCOUNT:   readdata_d = {16'd0, tocount_q};
            default:     readdata_d = 32'd0;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q          <= RST_CTRL;
            run_q           <= AUTO_START;
            to_q            <= 1'b0;
            period_q        <= RST_PERIOD;
            counter_q       <= RST_PERIOD;
            snap_q          <= CNT_ZERO;
            prescale_q      <= PRE_ZERO;
            pre_cnt_q       <= PRE_ZERO;
            tocount_q       <= 16'd0;
            force_reload_q  <= 1'b0;
            readdata_q      <= 32'd0;
            timeout_pulse_q <= 1'b0;
        end else begin
            ctrl_q          <= ctrl_d;
            run_q           <= run_d;
            to_q            <= to_d;
            period_q        <= period_d;
            counter_q       <= counter_d;
            snap_q          <= snap_d;
            prescale_q      <= prescale_d;
            pre_cnt_q       <= pre_cnt_d;
            tocount_q       <= tocount_d;
            force_reload_q  <= force_reload_d;
            readdata_q      <= readdata_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign bus.readdata  = readdata_q;
    assign timeout_pulse = timeout_pulse_q;
    assign irq           = to_q && ctrl_q[0];

endmodule

// File: tb/tb_param_interval_timer.sv
// Randomized and directed bench for param_interval_timer: a cycle-level
// behavioural model of the register map is compared against the DUT every cycle.
module tb_param_interval_timer;

    logic clk = 1'b0;
    logic reset;
    logic irq, tp, irq40, tp40;

    always #5 clk = ~clk;

    param_interval_timer_if bus();
    param_interval_timer_if bus40();

    param_interval_timer u_dut (
        .clk(clk), .reset(reset), .bus(bus), .irq(irq), .timeout_pulse(tp)
    );

    param_interval_timer #(
        .COUNTER_WIDTH(40), .RESET_PERIOD(64'd1000), .PRESCALE_WIDTH(4), .AUTO_START(1'b1)
    ) u_dut40 (
        .clk(clk), .reset(reset), .bus(bus40), .irq(irq40), .timeout_pulse(tp40)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state for u_dut (32-bit counter, 8-bit prescaler, no auto start)
    bit        m_run, m_to, m_fr, m_pulse;
    bit [3:0]  m_ctrl;
    bit [31:0] m_per, m_cnt, m_snap, m_rd;
    int        m_ps, m_wait, m_toc;

    // m_wait = clock cycles left before the next tick while running
    task automatic model_step();
        bit        we, ticked, expired, st, sp;
        bit [2:0]  a;
        bit [31:0] d;
        if (reset) begin
            m_run = 1'b0; m_to = 1'b0; m_fr = 1'b0; m_pulse = 1'b0; m_ctrl = 4'd0;
            m_per = 32'd499; m_cnt = 32'd499; m_snap = 32'd0; m_rd = 32'd0;
            m_ps = 0; m_wait = 0; m_toc = 0;
            return;
        end
        we = bus.chipselect && !bus.write_n;
        a  = bus.address;
        d  = bus.writedata;
        case (a)
            3'd0:    m_rd = {30'd0, m_run, m_to};
            3'd1:    m_rd = {28'd0, m_ctrl};
            3'd2:    m_rd = m_per;
            3'd4:    m_rd = m_snap;
            3'd6:    m_rd = 32'(m_ps);
            3'd7:    m_rd = 32'(m_toc);
            default: m_rd = 32'd0;
        endcase
        ticked  = m_run && (m_wait == 0);
        expired = ticked && (m_cnt == 32'd0);
        st = we && (a == 3'd1) && d[2];
        sp = we && (a == 3'd1) && d[3];
        if (we && (a == 3'd4 || a == 3'd5)) m_snap = m_cnt;
        if (m_run) m_wait = ticked ? m_ps : m_wait - 1;
        if (ticked) m_cnt = expired ? m_per : m_cnt - 32'd1;
        if (expired && !m_ctrl[1]) m_run = 1'b0;
        if (m_fr) begin m_cnt = m_per; m_run = 1'b0; m_wait = m_ps; end
        if (sp) m_run = 1'b0;
        if (st) begin m_run = 1'b1; m_wait = m_ps; end
        if (we && a == 3'd0) begin m_to = 1'b0; m_toc = 0; end
        if (expired) begin
            m_to  = 1'b1;
            m_toc = (m_toc >= 65535) ? 65535 : m_toc + 1;
        end
        m_pulse = expired;
        if (we && a == 3'd1) m_ctrl = d[3:0];
        if (we && a == 3'd2) m_per = d;
        if (we && a == 3'd6) m_ps = int'(d[7:0]);
        m_fr = we && (a == 3'd2 || a == 3'd3);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("readdata", bus.readdata, m_rd);
        check("irq", irq, m_to && m_ctrl[0]);
        check("timeout_pulse", tp, m_pulse);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        cycle();
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        bus.address = a;
        cycle();
        v = bus.readdata;
    endtask

    task automatic wr40(input logic [2:0] a, input logic [31:0] d);
        bus40.address = a; bus40.writedata = d; bus40.chipselect = 1'b1; bus40.write_n = 1'b0;
        cycle();
        bus40.chipselect = 1'b0; bus40.write_n = 1'b1;
    endtask

    task automatic rd40(input logic [2:0] a, output logic [31:0] v);
        bus40.address = a;
        cycle();
        v = bus40.readdata;
    endtask

    task automatic wait_pulse(input int bound, output int waited);
        waited = 0;
        do begin
            cycle();
            waited++;
        end while (tp !== 1'b1 && waited < bound);
        check("pulse_wait", tp, 1'b1);
    endtask

    initial begin
        logic [31:0] v;
        int w;
        reset = 1'b1;
        bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
        bus40.address = 3'd0; bus40.chipselect = 1'b0; bus40.write_n = 1'b1; bus40.writedata = 32'd0;
        cycle(); cycle();
        reset = 1'b0;
        check("rst_readdata", bus.readdata, 32'd0);
        check("rst_irq", irq, 1'b0);
        check("rst_pulse", tp, 1'b0);
        check("rst_irq40", irq40, 1'b0);
        check("rst_pulse40", tp40, 1'b0);
        rd(3'd0, v); check("rst_status", v, 32'd0);
        rd(3'd2, v); check("rst_period_lo", v, 32'd499);
        rd(3'd1, v); check("rst_control", v, 32'd0);
        rd(3'd7, v); check("rst_tocount", v, 32'd0);
        rd(3'd6, v); check("rst_prescale", v, 32'd0);
        rd(3'd4, v); check("rst_snap_lo", v, 32'd0);

        // Auto-start, 40-bit instance: reset state, then wide period and snapshot
        rd40(3'd0, v); check("w40_rst_status", v, 32'd2);
        rd40(3'd1, v); check("w40_rst_control", v, 32'd2);
        rd40(3'd2, v); check("w40_rst_period_lo", v, 32'd1000);
        rd40(3'd3, v); check("w40_rst_period_hi", v, 32'd0);
        wr40(3'd6, 32'h35); rd40(3'd6, v); check("w40_prescale_trunc", v, 32'h5);
        wr40(3'd6, 32'h0);
        wr40(3'd3, 32'hFFFF_FF12);
        wr40(3'd2, 32'h34);
        cycle();
        wr40(3'd1, 32'h6);
        repeat (10) cycle();
        wr40(3'd4, 32'hDEAD_BEEF);
        rd40(3'd5, v); check("w40_snap_hi", v, 32'h12);
        rd40(3'd4, v); check("w40_snap_lo", v, 32'h2A);
        rd40(3'd3, v); check("w40_period_hi", v, 32'h12);

        // Reset timer: CONT+ITO+START, 500 ticks then registered pulse
        reset = 1'b1; cycle(); reset = 1'b0;
        wr(3'd1, 32'h7);
        wait_pulse(2000, w);
        check("r27_latency", 1 + w, 501);
        check("r27_irq", irq, 1'b1);
        rd(3'd0, v); check("r27_status", v, 32'd3);

        // One-shot period 3
        wr(3'd1, 32'h8);
        wr(3'd0, 32'd0);
        wr(3'd3, 32'hABCD); rd(3'd3, v); check("period_hi_32", v, 32'd0);
        wr(3'd2, 32'd3);
        cycle();
        wr(3'd1, 32'h4);
        wait_pulse(50, w);
        check("r28_ticks", w, 4);
        repeat (20) cycle();
        rd(3'd0, v); check("r28_status", v, 32'd1);
        rd(3'd7, v); check("r28_tocount", v, 32'd1);
        wr(3'd4, 32'd0);
        rd(3'd4, v); check("r28_counter", v, 32'd3);

        // Prescale 2, period 1, continuous: 6-cycle interval, coincident STATUS write
        wr(3'd1, 32'h8);
        wr(3'd0, 32'd0);
        wr(3'd6, 32'd2);
        wr(3'd2, 32'd1);
        cycle();
        wr(3'd1, 32'h6);
        wait_pulse(50, w); check("r29_first", w, 6);
        wait_pulse(50, w); check("r29_interval", w, 6);
        repeat (5) cycle();
        wr(3'd0, 32'd0);
        check("r29_coincident_pulse", tp, 1'b1);
        rd(3'd0, v); check("r29_status", v, 32'd3);
        rd(3'd7, v); check("r29_tocount", v, 32'd1);

        // START+STOP together, then START on the force_reload cycle
        wr(3'd1, 32'h8);
        wr(3'd1, 32'hC);
        rd(3'd0, v); check("r31_run_start_stop", v[1], 1'b1);
        wr(3'd6, 32'd50);
        wr(3'd2, 32'd7);
        wr(3'd1, 32'h6);
        wr(3'd4, 32'd0);
        rd(3'd4, v); check("r31_counter", v, 32'd7);
        rd(3'd0, v); check("r31_run", v[1], 1'b1);

        // Randomized bus traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            bus.address = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 499) == 0);
            if (r < 12) begin
                bus.chipselect = 1'b1; bus.write_n = 1'b0;
                case (bus.address)
                    3'd2:    bus.writedata = $urandom_range(0, 12);
                    3'd6:    bus.writedata = $urandom_range(0, 3);
                    3'd1:    bus.writedata = ($urandom & 32'hFFFF_FFF0) | $urandom_range(0, 15);
                    default: bus.writedata = $urandom;
                endcase
            end else begin
                bus.chipselect = 1'($urandom_range(0, 1)); bus.write_n = 1'b1;
                bus.writedata = $urandom;
            end
            cycle();
        end
        reset = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;

        // Period 0 continuous: TOCOUNT saturates, then reset mid-run
        wr(3'd1, 32'h8);
        wr(3'd6, 32'd0);
        wr(3'd0, 32'd0);
        wr(3'd2, 32'd0);
        cycle();
        wr(3'd1, 32'h6);
        repeat (70000) cycle();
        rd(3'd7, v); check("r32_tocount_sat", v, 32'hFFFF);
        bus.address = 3'd1; bus.writedata = 32'h7; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        check("r32_rst_readdata", bus.readdata, 32'd0);
        check("r32_rst_irq", irq, 1'b0);
        check("r32_rst_pulse", tp, 1'b0);
        rd(3'd0, v); check("r32_status", v, 32'd0);
        rd(3'd1, v); check("r32_control", v, 32'd0);
        rd(3'd2, v); check("r32_period", v, 32'd499);
        rd(3'd7, v); check("r32_tocount", v, 32'd0);
        rd(3'd6, v); check("r32_prescale", v, 32'd0);
        rd(3'd4, v); check("r32_snap", v, 32'd0);
        wr(3'd5, 32'd0);
        rd(3'd4, v); check("r32_counter", v, 32'd499);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
